edge_detect: RTL and testbench

Registered multi-bit edge detector. Samples a level signal on `clk` and emits one-cycle pulses on rising, falling and either transition of each bit. It sits between slow or asynchronous status or control levels and the event logic that consumes single-cycle strobes. An optional input synchronizer allows safe use on asynchronous inputs.

---
 rtl/edge_detect.sv | 91 +++++++++
 tb/tb_edge_detect.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - registered multi-bit rising/falling/any edge detector
// Optional feature macro: EDGE_DETECT_SYNC_EN
//   (adds a SYNC_STAGES-deep input synchronizer ahead of the capture register)
// Parameters:
//   WIDTH       - number of independent input bits
//   SYNC_STAGES - synchronizer depth (2..4), used only with EDGE_DETECT_SYNC_EN
//   RESET_VAL   - reset value of every input-history flop, replicated to WIDTH
// Ports:
//   clk      - clock, all logic on the rising edge
//   rst_n    - asynchronous active-low reset
//   sig_in   - [WIDTH] monitored levels
//   pos_edge - [WIDTH] one-cycle pulse per bit on a 0->1 transition
//   neg_edge - [WIDTH] one-cycle pulse per bit on a 1->0 transition
//   any_edge - [WIDTH] one-cycle pulse per bit on either transition
module edge_detect #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2,
  parameter bit RESET_VAL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sig_in,
  output logic [WIDTH-1:0] pos_edge,
  output logic [WIDTH-1:0] neg_edge,
  output logic [WIDTH-1:0] any_edge
);

`ifdef EDGE_DETECT_SYNC_EN
  localparam bit SYNC_EN = 1'b1;
`else
  localparam bit SYNC_EN = 1'b0;
`endif

  // Zero depth means sig_in feeds the capture register directly.
  localparam int DEPTH = SYNC_EN ? SYNC_STAGES : 0;

  localparam logic [WIDTH-1:0] RST_VEC = {WIDTH{RESET_VAL}};

  logic [WIDTH-1:0] w_cap_d;
  logic [WIDTH-1:0] r_in_q;
  logic [WIDTH-1:0] r_prev_q;
  logic [WIDTH-1:0] r_pos;
  logic [WIDTH-1:0] r_neg;
  logic [WIDTH-1:0] r_any;

  generate
    if (DEPTH > 0) begin : g_sync
      logic [WIDTH-1:0] r_sync [DEPTH];

      // Sync chain resets to RESET_VAL so a post-reset level that differs
      // from RESET_VAL still shows up as an edge once it propagates.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            r_sync[i] <= RST_VEC;
          end
        end else begin
          r_sync[0] <= sig_in;
          for (int i = 1; i < DEPTH; i++) begin
            r_sync[i] <= r_sync[i-1];
          end
        end
      end

      assign w_cap_d = r_sync[DEPTH-1];
    end else begin : g_nosync
      assign w_cap_d = sig_in;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_q   <= RST_VEC;
      r_prev_q <= RST_VEC;
      r_pos    <= '0;
      r_neg    <= '0;
      r_any    <= '0;
    end else begin
      r_in_q   <= w_cap_d;
      r_prev_q <= r_in_q;
      r_pos    <= r_in_q & ~r_prev_q;
      r_neg    <= ~r_in_q & r_prev_q;
      r_any    <= r_in_q ^ r_prev_q;
    end
  end

  assign pos_edge = r_pos;
  assign neg_edge = r_neg;
  assign any_edge = r_any;

endmodule

// File: tb/tb_edge_detect.sv
// tb/tb_edge_detect.sv - self-checking bench for edge_detect (WIDTH=4)
module tb_edge_detect;

`ifdef EDGE_DETECT_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sig_in = 4'b0000;
  logic [3:0] pos_edge;
  logic [3:0] neg_edge;
  logic [3:0] any_edge;

  int compared = 0;
  int failed   = 0;

  // Samples of sig_in taken at each rising edge, oldest first.
  logic [3:0] samp[$];
  logic [3:0] e_pos, e_neg, e_any;

  edge_detect #(
    .WIDTH       (4),
    .SYNC_STAGES (2),
    .RESET_VAL   (1'b0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig_in   (sig_in),
    .pos_edge (pos_edge),
    .neg_edge (neg_edge),
    .any_edge (any_edge)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Model: an edge is reported on the output when the two consecutive
  // samples (L+1 and L+2 edges old) differ.
  task automatic cycle(input logic [3:0] v);
    @(negedge clk);
    sig_in = v;
    @(posedge clk);
    samp.push_back(v);
    while (samp.size() > L + 3) void'(samp.pop_front());
    #1;
    e_pos = samp[1] & ~samp[0];
    e_neg = ~samp[1] & samp[0];
    e_any = samp[1] ^ samp[0];
    compared += 4;
    if (pos_edge !== e_pos) begin
      failed++;
      $display("FAIL pos_edge actual=%b required=%b t=%0t", pos_edge, e_pos, $time);
    end
    if (neg_edge !== e_neg) begin
      failed++;
      $display("FAIL neg_edge actual=%b required=%b t=%0t", neg_edge, e_neg, $time);
    end
    if (any_edge !== e_any) begin
      failed++;
      $display("FAIL any_edge actual=%b required=%b t=%0t", any_edge, e_any, $time);
    end
    if ((pos_edge & neg_edge) !== 4'b0000) begin
      failed++;
      $display("FAIL pos_and_neg actual=%b required=0000 t=%0t", pos_edge & neg_edge, $time);
    end
  endtask

  task automatic do_reset(input logic [3:0] v);
    sig_in = v;
    rst_n  = 1'b0;
    #1;
    compared++;
    if ({pos_edge, neg_edge, any_edge} !== 12'h000) begin
      failed++;
      $display("FAIL reset_outputs actual=%h required=000", {pos_edge, neg_edge, any_edge});
    end
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if ({pos_edge, neg_edge, any_edge} !== 12'h000) begin
      failed++;
      $display("FAIL reset_hold actual=%h required=000", {pos_edge, neg_edge, any_edge});
    end
    #1;
    rst_n = 1'b1;
    samp.delete();
    for (int i = 0; i < L + 3; i++) samp.push_back(4'b0000);
  endtask

  task automatic test_reset;
    int nz;
    nz = 0;
    do_reset(4'b0000);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0000);
      if ({pos_edge, neg_edge, any_edge} != 12'h000) nz++;
    end
    compared++;
    if (nz != 0) begin
      failed++;
      $display("FAIL reset_quiet actual=%0d required=0", nz);
    end
  endtask

  task automatic test_single_rise;
    int cnt, at, negs;
    cnt = 0; at = -1; negs = 0;
    for (int i = 0; i < 3 + L + 2; i++) begin
      cycle(4'b0001);
      if (pos_edge[0] && any_edge[0]) begin
        cnt++;
        at = i;
      end
      if (neg_edge[0]) negs++;
    end
    compared += 3;
    if (cnt != 1) begin
      failed++;
      $display("FAIL rise_count actual=%0d required=1", cnt);
    end
    if (at != L + 1) begin
      failed++;
      $display("FAIL rise_latency actual=%0d required=%0d", at, L + 1);
    end
    if (negs != 0) begin
      failed++;
      $display("FAIL rise_neg actual=%0d required=0", negs);
    end
    for (int i = 0; i < L + 3; i++) cycle(4'b0000);
  endtask

  task automatic test_sequence;
    logic [7:0] seq;
    logic [1:0] got[$];
    logic [1:0] want[7];
    seq  = 8'b0110_1101;  // MSB first: 0,1,1,0,1,1,0,1
    want = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10};
    for (int i = 0; i < 8 + L + 2; i++) begin
      cycle({3'b000, (i < 8) ? seq[7-i] : 1'b1});
      got.push_back({pos_edge[0], neg_edge[0]});
    end
    // Output for the transition into element j appears L+1 cycles later.
    for (int j = 1; j < 8; j++) begin
      compared++;
      if (got[j + L + 1] !== want[j-1]) begin
        failed++;
        $display("FAIL seq_step%0d actual=%b required=%b", j, got[j + L + 1], want[j-1]);
      end
    end
    for (int i = 0; i < L + 3; i++) cycle(4'b0000);
  endtask

  task automatic test_width4;
    logic [3:0] p[$], n[$];
    logic [3:0] vals[3];
    vals = '{4'b0000, 4'b0101, 4'b0011};
    for (int i = 0; i < 3 + L + 2; i++) begin
      cycle(vals[(i < 3) ? i : 2]);
      p.push_back(pos_edge);
      n.push_back(neg_edge);
    end
    compared += 4;
    if (p[L + 2] !== 4'b0101 || p[L + 3] !== 4'b0010) begin
      failed++;
      $display("FAIL w4_pos actual=%b,%b required=0101,0010", p[L + 2], p[L + 3]);
    end
    if (n[L + 2] !== 4'b0000 || n[L + 3] !== 4'b0100) begin
      failed++;
      $display("FAIL w4_neg actual=%b,%b required=0000,0100", n[L + 2], n[L + 3]);
    end
    if (p[L + 4] !== 4'b0000) begin
      failed++;
      $display("FAIL w4_pos_after actual=%b required=0000", p[L + 4]);
    end
    if (n[L + 4] !== 4'b0000) begin
      failed++;
      $display("FAIL w4_neg_after actual=%b required=0000", n[L + 4]);
    end
    for (int i = 0; i < L + 3; i++) cycle(4'b0000);
  endtask

  task automatic test_reset_mid_pulse;
    int cnt;
    cnt = 0;
    for (int i = 0; i < L + 2; i++) cycle(4'b0001);
    compared++;
    if (pos_edge[0] !== 1'b1) begin
      failed++;
      $display("FAIL midrst_pulse actual=%b required=1", pos_edge[0]);
    end
    do_reset(4'b0001);
    for (int i = 0; i < L + 5; i++) begin
      cycle(4'b0001);
      if (pos_edge[0]) cnt++;
    end
    compared++;
    if (cnt != 1) begin
      failed++;
      $display("FAIL midrst_release_pulses actual=%0d required=1", cnt);
    end
    for (int i = 0; i < L + 3; i++) cycle(4'b0000);
  endtask

  task automatic test_toggle;
    int run, best, total;
    run = 0; best = 0; total = 0;
    for (int i = 0; i < 6 + L + 3; i++) begin
      cycle((i < 6 && (i % 2 == 0)) ? 4'b1111 : 4'b0000);
      if (any_edge == 4'b1111) begin
        run++;
        total++;
        if (run > best) best = run;
      end else begin
        run = 0;
      end
    end
    compared += 2;
    if (best != 6) begin
      failed++;
      $display("FAIL toggle_run actual=%0d required=6", best);
    end
    if (total != 6) begin
      failed++;
      $display("FAIL toggle_total actual=%0d required=6", total);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 300; i++) begin
      if (i == 150) do_reset(4'($urandom));
      cycle(4'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_single_rise();
    test_sequence();
    test_width4();
    test_reset_mid_pulse();
    test_toggle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
